fp_add_seq: RTL and testbench

//  Multi-cycle sequencer for the single-precision FP add/sub datapath. It accepts one

---
 rtl/fp_add_seq_if.sv | 34 +++
 rtl/fp_add_seq.sv | 119 +++++++++++
 tb/tb_fp_add_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_add_seq_if.sv
// Handshake and datapath-control bundle between the FPU issue logic and the add sequencer.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface fp_add_seq_if #(
  parameter int unsigned EXP_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic             special;
  logic             ld_en;
  logic             swap_sel;
  logic             shift_en;
  logic             add_en;
  logic             norm_en;
  logic             norm_done;
  logic             rnd_en;
  logic [EXP_W-1:0] exp_res;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, exp_a, exp_b, special, norm_done, out_ready,
    input  in_ready, ld_en, swap_sel, shift_en, add_en, norm_en, rnd_en,
           exp_res, out_valid, busy
  );

  modport slave (
    input  in_valid, exp_a, exp_b, special, norm_done, out_ready,
    output in_ready, ld_en, swap_sel, shift_en, add_en, norm_en, rnd_en,
           exp_res, out_valid, busy
  );
endinterface

// File: rtl/fp_add_seq.sv
// Multi-cycle sequencer for the single-precision FP add/sub datapath: exponent compare,
// 1-bit/cycle alignment, then add, normalize and round strobes with valid/ready on both ends.
module fp_add_seq #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAX_SHIFT = 26
) (
  input  logic         clk,
  input  logic         reset,
  fp_add_seq_if.slave  io
);
  localparam int unsigned SHW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, ROUND, DONE} state_e;

  state_e           state_q, state_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d;
  logic [EXP_W-1:0] exp_b_q, exp_b_d;
  logic [EXP_W-1:0] exp_res_q, exp_res_d;
  logic             swap_q, swap_d;
  logic [SHW-1:0]   shift_cnt_q, shift_cnt_d;

  logic [EXP_W:0]   diff;
  logic [EXP_W:0]   mag;
  logic             borrow;
  logic [SHW-1:0]   shift_sat;

  // Difference wraps modulo 2^(EXP_W+1); the top bit is the borrow.
  always_comb begin
    diff      = {1'b0, exp_a_q} - {1'b0, exp_b_q};
    borrow    = diff[EXP_W];
    mag       = borrow ? (~diff + 1'b1) : diff;
    shift_sat = (mag > (EXP_W+1)'(MAX_SHIFT)) ? SHW'(MAX_SHIFT) : SHW'(mag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      exp_res_q   <= '0;
      swap_q      <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      exp_res_q   <= exp_res_d;
      swap_q      <= swap_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    exp_res_d   = exp_res_q;
    swap_d      = swap_q;
    shift_cnt_d = shift_cnt_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          exp_a_d     = io.exp_a;
          exp_b_d     = io.exp_b;
          exp_res_d   = '0;
          swap_d      = 1'b0;
          shift_cnt_d = '0;
          state_d     = io.special ? DONE : CMP;
        end
      end
      CMP: begin
        swap_d      = borrow;
        exp_res_d   = borrow ? exp_b_q : exp_a_q;
        shift_cnt_d = shift_sat;
        state_d     = (shift_sat != '0) ? ALIGN : ADD;
      end
      ALIGN: begin
        shift_cnt_d = shift_cnt_q - 1'b1;
        if (shift_cnt_q == SHW'(1)) state_d = ADD;
      end
      ADD:   state_d = NORM;
      NORM:  if (io.norm_done) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, in_ready included.
  always_comb begin
    io.in_ready  = 1'b0;
    io.ld_en     = 1'b0;
    io.swap_sel  = 1'b0;
    io.shift_en  = 1'b0;
    io.add_en    = 1'b0;
    io.norm_en   = 1'b0;
    io.rnd_en    = 1'b0;
    io.exp_res   = '0;
    io.out_valid = 1'b0;
    io.busy      = 1'b0;
    if (!reset) begin
      io.swap_sel = swap_q;
      io.exp_res  = exp_res_q;
      io.busy     = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          io.in_ready = 1'b1;
          io.ld_en    = io.in_valid;
        end
        ALIGN:   io.shift_en  = 1'b1;
        ADD:     io.add_en    = 1'b1;
        NORM:    io.norm_en   = 1'b1;
        ROUND:   io.rnd_en    = 1'b1;
        DONE:    io.out_valid = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: hand-computed shift counts, swap, exponent and latency
// per vector, plus back-pressure, delayed normalize and reset-abort scenarios.
module tb_fp_add_seq;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  fp_add_seq_if #(.EXP_W(8)) bus ();

  fp_add_seq #(.EXP_W(8), .MAX_SHIFT(26)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {16'd0, bus.in_ready, bus.ld_en, bus.swap_sel, bus.shift_en, bus.add_en,
            bus.norm_en, bus.rnd_en, bus.out_valid, bus.exp_res};
  endfunction

  // One transaction: K = NORM cycles until norm_done, R = DONE cycles with out_ready low.
  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sp, input int k_norm, input int r_hold,
                         input logic exp_sw, input int exp_n, input logic [7:0] exp_er,
                         input int exp_lat);
    int t, n_shift, n_add, n_norm, n_rnd, t_valid, n_valid, n_xfer, hold_bad, rdy_bad;
    logic done;
    @(negedge clk);
    check_eq({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.exp_a    = a;
    bus.exp_b    = b;
    bus.special  = sp;
    bus.in_valid = 1'b1;
    #1;
    check_eq({tag, "/ld_en"}, 32'(bus.ld_en), 32'd1);
    t = 0; n_shift = 0; n_add = 0; n_norm = 0; n_rnd = 0; t_valid = -1;
    n_valid = 0; n_xfer = 0; hold_bad = 0; rdy_bad = 0; done = 1'b0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
      bus.in_valid  = 1'b0;
      bus.norm_done = 1'b0;
      bus.out_ready = 1'b0;
      if (bus.busy && bus.in_ready) rdy_bad++;
      if (bus.busy && (t >= 2 || sp) && (bus.swap_sel !== exp_sw || bus.exp_res !== exp_er))
        hold_bad++;
      if (bus.shift_en) n_shift++;
      if (bus.add_en) n_add++;
      if (bus.rnd_en) n_rnd++;
      if (bus.norm_en) begin
        n_norm++;
        bus.norm_done = (n_norm >= k_norm);
      end
      if (bus.out_valid) begin
        if (t_valid < 0) t_valid = t;
        n_valid++;
        if (n_valid > r_hold) begin
          bus.out_ready = 1'b1;
          n_xfer++;
          done = 1'b1;
        end
      end
    end
    check_eq({tag, "/completed"}, 32'(done), 32'd1);
    check_eq({tag, "/shift_cycles"}, 32'(n_shift), 32'(exp_n));
    check_eq({tag, "/add_cycles"}, 32'(n_add), sp ? 32'd0 : 32'd1);
    check_eq({tag, "/norm_cycles"}, 32'(n_norm), sp ? 32'd0 : 32'(k_norm));
    check_eq({tag, "/rnd_cycles"}, 32'(n_rnd), sp ? 32'd0 : 32'd1);
    check_eq({tag, "/latency"}, 32'(t_valid), 32'(exp_lat));
    check_eq({tag, "/valid_cycles"}, 32'(n_valid), 32'(r_hold + 1));
    check_eq({tag, "/hold_swap_exp"}, 32'(hold_bad), 32'd0);
    check_eq({tag, "/in_ready_busy"}, 32'(rdy_bad), 32'd0);
    check_eq({tag, "/transfers"}, 32'(n_xfer), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, "/back_idle"}, {30'd0, bus.busy, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    int stray;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.exp_a = '0; bus.exp_b = '0; bus.special = 1'b0;
    bus.norm_done = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", out_vec(), 32'd0);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_idle", {30'd0, bus.in_ready, bus.busy}, 32'd2);

    //       tag        a      b      sp   K  R  sw    N   exp_res lat
    run_txn("t1_a_gt",  8'h85, 8'h82, 1'b0, 1, 0, 1'b0, 3,  8'h85, 8);
    run_txn("t2_b_gt",  8'h7F, 8'h90, 1'b0, 1, 0, 1'b1, 17, 8'h90, 22);
    run_txn("t3_sat_a", 8'hFE, 8'h01, 1'b0, 1, 0, 1'b0, 26, 8'hFE, 31);
    run_txn("t3_sat_b", 8'h01, 8'hFE, 1'b0, 1, 0, 1'b1, 26, 8'hFE, 31);
    run_txn("wrap_max", 8'h00, 8'hFF, 1'b0, 1, 0, 1'b1, 26, 8'hFF, 31);
    run_txn("edge_26",  8'h20, 8'h06, 1'b0, 1, 0, 1'b0, 26, 8'h20, 31);
    run_txn("edge_27",  8'h06, 8'h21, 1'b0, 1, 0, 1'b1, 26, 8'h21, 31);
    run_txn("t4_spec",  8'h85, 8'h10, 1'b1, 1, 0, 1'b0, 0,  8'h00, 1);
    run_txn("t4_equal", 8'h40, 8'h40, 1'b0, 1, 0, 1'b0, 0,  8'h40, 5);
    run_txn("t5_stall", 8'h85, 8'h82, 1'b0, 3, 5, 1'b0, 3,  8'h85, 10);

    // Reset in the middle of alignment aborts the transaction.
    @(negedge clk);
    bus.exp_a = 8'h7F; bus.exp_b = 8'h90; bus.special = 1'b0; bus.in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.shift_en) seen++;
    end
    check_eq("t6_reached_align", 32'(seen), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_during_reset", out_vec(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_after_reset", {30'd0, bus.in_ready, bus.busy}, 32'd2);
    check_eq("t6_cleared", out_vec(), 32'h8000);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.shift_en || bus.add_en || bus.norm_en || bus.rnd_en) stray++;
    end
    check_eq("t6_no_strobes", 32'(stray), 32'd0);
    run_txn("t6_resume", 8'h85, 8'h82, 1'b0, 1, 0, 1'b0, 3, 8'h85, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
